// File: rtl/seg7_scan.sv
// Time-multiplexed seven-segment display driver.
// Scans N_DIGITS digits, one per rising edge of a slow strobe that is sampled
// in the system clock domain. A frame snapshot taken at each scan wrap keeps
// the displayed value from tearing while inputs change mid-frame.
module seg7_scan #(
    parameter int unsigned N_DIGITS      = 8,
    parameter bit          BLANK_LEADING = 1'b0
) (
    input  logic                          CLK100MHZ,
    input  logic                          rst,
    input  logic                          CLK1KHZ,
    input  logic [4*N_DIGITS-1:0]         data,
    input  logic [N_DIGITS-1:0]           dp,
    input  logic [N_DIGITS-1:0]           digit_en,
    output logic [N_DIGITS-1:0]           AN,
    output logic [6:0]                    SEG,
    output logic                          DP,
    output logic [$clog2(N_DIGITS)-1:0]   scan_idx
);

    localparam int unsigned IDX_W  = $clog2(N_DIGITS);
    localparam int unsigned DATA_W = 4 * N_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic                strb_q;
    logic                tick;
    logic [DATA_W-1:0]   sh_data;
    logic [N_DIGITS-1:0] sh_dp;
    logic [N_DIGITS-1:0] sh_en;

    logic [IDX_W+1:0]    bit_base;
    logic [3:0]          nib_c;
    logic                hi_zero_c;
    logic                blank_c;
    logic [N_DIGITS-1:0] an_c;
    logic [6:0]          seg_c;
    logic                dp_c;

    // Strobe edge detector; reset high so a strobe already high at release is not a tick.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) strb_q <= 1'b1;
        else     strb_q <= CLK1KHZ;
    end

    assign tick = CLK1KHZ & ~strb_q;

    // Digit scan counter, advancing one digit per strobe tick.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            scan_idx <= '0;
        end else if (tick) begin
            if (scan_idx == LAST_IDX) scan_idx <= '0;
            else                      scan_idx <= scan_idx + IDX_W'(1);
        end
    end

    // Frame snapshot, captured on the tick that wraps the scan back to digit 0.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            sh_data <= '0;
            sh_dp   <= '0;
            sh_en   <= '0;
        end else if (tick && (scan_idx == LAST_IDX)) begin
            sh_data <= data;
            sh_dp   <= dp;
            sh_en   <= digit_en;
        end
    end

    // Next display drive for the currently selected digit.
    always_comb begin
        bit_base  = {scan_idx, 2'b00};
        nib_c     = sh_data[bit_base +: 4];
        hi_zero_c = ((sh_data >> bit_base) == '0);
        blank_c   = ~sh_en[scan_idx] |
                    (BLANK_LEADING && (scan_idx != '0) && hi_zero_c);
        an_c      = '1;
        seg_c     = SEG_OFF;
        dp_c      = 1'b1;
        if (!blank_c) begin
            an_c  = ~(N_DIGITS'(1) << scan_idx);
            seg_c = decode(nib_c);
            dp_c  = ~sh_dp[scan_idx];
        end
    end

    // Registered display outputs, one clock behind the scan index.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            AN  <= '1;
            SEG <= SEG_OFF;
            DP  <= 1'b1;
        end else begin
            AN  <= an_c;
            SEG <= seg_c;
            DP  <= dp_c;
        end
    end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed 8-digit seven-segment display driver for the board's debug display of pipeline state (PC, register values).
- Sits directly downstream of the 1 kHz frequency divider and consumes its CLK1KHZ output as a scan strobe.
- Runs entirely in the CLK100MHZ domain. CLK1KHZ is sampled as data and never used as a clock.
- One digit advances per strobe rising edge, giving a 125 Hz full-frame refresh.

Parameters:
- N_DIGITS, 8, number of digits scanned; must be a power of two, 2..8.
- BLANK_LEADING, 0, when 1, leading zero nibbles are blanked; digit 0 is never blanked this way.

Ports:
- CLK100MHZ  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- CLK1KHZ  input  1  scan strobe level from the frequency divider; sampled, not a clock.
- data  input  4*N_DIGITS  hex value to display; digit i shows data[4i+3:4i].
- dp  input  N_DIGITS  decimal point request per digit; active-high.
- digit_en  input  N_DIGITS  per-digit enable; active-high.
- AN  output  N_DIGITS  anode selects; active-low, one-hot-low when lit.
- SEG  output  7  cathodes {g,f,e,d,c,b,a}; active-low.
- DP  output  1  decimal point cathode; active-low.
- scan_idx  output  log2(N_DIGITS)  index of the digit currently selected.

Behaviour:
- Strobe detect:
  - strb_q <= CLK1KHZ every cycle; reset value 1, so a high strobe at reset release gives no tick.
  - tick = CLK1KHZ & ~strb_q, one CLK100MHZ cycle wide.
- Scan counter:
  - scan_idx resets to 0.
  - On tick, scan_idx <= scan_idx+1 modulo N_DIGITS; N_DIGITS-1 wraps to 0.
  - With no tick, scan_idx holds.
- Frame snapshot:
  - Shadow registers sh_data, sh_dp, sh_en reset to 0.
  - Loaded from data, dp, digit_en on a tick while scan_idx==N_DIGITS-1 (frame wrap).
  - Loaded values are those present at that clock edge.
  - Input changes mid-frame are ignored until the next wrap, so there is no tearing.
- Output stage (registered):
  - Each cycle, AN/SEG/DP are computed from the current scan_idx and the shadow registers.
  - Outputs therefore lag scan_idx by exactly one clock.
  - Tick seen at edge T → scan_idx changes after edge T → outputs change after edge T+1.
- Lit digit:
  - AN bit scan_idx = 0, all other AN bits = 1.
  - SEG = decode of the nibble; DP = ~sh_dp[scan_idx].
- Blank digit (sh_en[scan_idx]==0, or leading-zero blanked):
  - AN = all 1s, SEG = 7'h7F, DP = 1.
- Leading-zero blank (BLANK_LEADING=1 only):
  - Digit i>0 is blanked when nibbles i..N_DIGITS-1 of sh_data are all zero.
  - A set sh_dp bit on such a digit does not unblank it.
- Decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Reset values:
  - AN = all 1s, SEG = 7'h7F, DP = 1, scan_idx = 0, shadow = 0.
  - The display stays dark until the first frame wrap loads the shadow.
  - Asserting rst mid-frame restores these values at the next edge and discards the current frame.
- Strobe held constant (high or low): no ticks; scan_idx and outputs hold.

Test Plan:
- Reset: rst=1 for 3 cycles with CLK1KHZ=1 → AN=FF, SEG=7F, DP=1, scan_idx=0; after release with CLK1KHZ held 1, no tick and outputs unchanged.
- Scan order and latency: data=32'h76543210, digit_en=FF; pulse CLK1KHZ 8 times to wrap, then pulse 8 more → scan_idx visits 0..7 and wraps to 0; each AN (FE,FD,...,7F) appears one clock after the scan_idx change; SEG follows the decode table, digit 3 showing 0110000.
- Snapshot: change data to 32'hFFFFFFFF while scan_idx=3 → digits 4..7 still show 4..7; after the wrap tick, digit 0 shows F (0001110).
- Enables and decimal points: digit_en=8'h0F, dp=8'h01 → digit 0 has DP=0; digits 4..7 give AN=FF, SEG=7F, DP=1.
- Leading-zero blanking: BLANK_LEADING=1, data=32'h00000A00 → digits 3..7 blank; digit 2 shows A (0001000); digits 1 and 0 show 0. data=0 → only digit 0 lit.
- Mid-frame reset: assert rst at scan_idx=5 → next edge gives scan_idx=0, AN=FF; the display stays dark until the next frame wrap.
